qspi_multi_cs_engine: RTL
=========================

Name: qspi_multi_cs_engine

Overview:
Byte-oriented QSPI transaction engine that serves NUM_CS serial devices (PSRAM, NOR, ...) over one shared 4-bit sio bus. Each device has its own CE and gated SCLK. The SoC-side bus issues one byte per request, selects single-bit or quad mode per byte, and keeps CE low across bytes until a request is marked last. It replaces fixed two-device pin wiring with a depth/width-generic controller in the soc layer.

Parameters:
NUM_CS, 2, number of chip selects / SCLK outputs (>=1)
CS_W, $clog2(NUM_CS) min 1, width of req_cs
CLK_DIV, 1, SCLK half-period in clk cycles (>=1)
CE_GAP, 2, minimum clk cycles CE stays high between transactions (>=1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  byte request valid
req_ready  out  1  engine accepts request this cycle
req_cs  in  CS_W  target device; sampled only on the first byte of a transaction
req_quad  in  1  1 = 4-bit transfer, 0 = 1-bit transfer
req_rd  in  1  1 = return the received byte on rsp
req_last  in  1  deassert CE after this byte
req_wdata  in  8  byte to shift out
rsp_valid  out  1  one-cycle pulse, read byte available
rsp_rdata  out  8  received byte
busy  out  1  high in any state except IDLE
ce_n  out  NUM_CS  active-low chip enables
sclk  out  NUM_CS  per-device SPI clock, mode 0
sio_i  in  4  sio pad inputs
sio_o  out  4  sio pad outputs
sio_oe  out  4  sio output enables, 1 = drive

Behaviour:
- Reset, asynchronous: state IDLE, ce_n all 1, sclk all 0, sio_o 0, sio_oe 0, rsp_valid 0, rsp_rdata 0, busy 0.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, DONE, OPEN, GAP.
- req_ready is 1 only in IDLE and OPEN. A request is accepted on req_valid & req_ready.
- IDLE:
  - On accept: latch cs from req_cs, drive ce_n[cs]=0, load the shift register, drive the first bits, go to SHIFT_LO.
- SHIFT_LO:
  - sclk[cs]=0 for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI:
  - sclk[cs]=1 for CLK_DIV cycles.
  - Sample sio_i in the last cycle of the high phase.
  - Then either drive the next bits and return to SHIFT_LO, or go to DONE when the bit count is exhausted.
- Single mode:
  - 8 SCLK periods, MSB first.
  - Output on sio_o[0]; sample sio_i[1].
  - sio_oe=4'b0001 for both reads and writes (wdata is shifted out during reads).
- Quad mode:
  - 2 SCLK periods, high nibble first, on sio[3:0].
  - sio_oe=4'b1111 when req_rd=0, 4'b0000 when req_rd=1.
- DONE (1 cycle):
  - rsp_valid=1 and rsp_rdata updated if rd; rsp_rdata otherwise holds its value.
  - Go to GAP if last, else to OPEN.
- OPEN:
  - ce_n[cs] stays 0, sclk 0, sio_oe 0.
  - On accept: load the shift register and go to SHIFT_LO.
  - req_cs is ignored; the latched cs is used.
  - Mode may change per byte (single command, then quad data).
- GAP:
  - ce_n all 1, sio_oe 0, for CE_GAP cycles, then go to IDLE.
- Latency: accept at cycle T; DONE and rsp_valid at T+1+16*CLK_DIV (single) or T+1+4*CLK_DIV (quad).
- Non-selected sclk and ce_n stay inactive at all times. At most one ce_n is low at any time.
- req_cs >= NUM_CS: the request is accepted and shifted with no CE or SCLK asserted; rsp_rdata is undefined. Verification checks that no ce_n asserts.
- resetn low mid-byte: all outputs return to reset values immediately; the partial byte is lost and there is no rsp_valid.
- OPEN with no request holds CE low indefinitely; there is no timeout.

Decomposition:
- Package qspi_pkg:
  - state enum (6 states, 3 bits)
  - constants BITS_SINGLE=8, BITS_QUAD=2 (sclk periods per byte)
  - oe constants OE_SINGLE=4'b0001, OE_QUAD_WR=4'b1111, OE_IN=4'b0000
- Sub-module qspi_sclk_phase: CLK_DIV half-period counter producing phase_end and rise/fall strobes. Shifter and FSM stay in the top.

Test Plan:
1. CLK_DIV=1, write 0x9F single, cs=0, last=1 at T:
   - sio_o[0] sequence 1,0,0,1,1,1,1,1 on 8 sclk[0] pulses; sclk[1] stays 0.
   - No rsp_valid; ce_n[0] high at T+18 for 2 cycles, then req_ready=1.
2. Quad read, cs=1, CLK_DIV=1, sio_i = 0xA in period 1 and 0x5 in period 2:
   - sio_oe=0000, rsp_valid at T+5, rsp_rdata=0xA5.
3. Three-byte transaction (single 0xEB, quad write 0x12, quad read last) to cs=0, with req_cs=1 on bytes 2-3:
   - ce_n[0] low throughout, ce_n[1] never low.
   - sio_oe sequence 0001 → 1111 → 0000.
4. CLK_DIV=3, single byte:
   - sclk high/low exactly 3 cycles each; rsp at T+49.
5. resetn pulsed low during SHIFT_HI of byte 1:
   - ce_n all 1, sclk 0, sio_oe 0 immediately; no rsp_valid; next request accepted from IDLE.
6. Back-to-back last-byte requests to cs=0 then cs=1:
   - ce_n high for ≥ CE_GAP cycles between them; never both low.

Source files
------------

// File: rtl/qspi_pkg.sv
// qspi_pkg: state encoding, per-byte period counts and output-enable patterns for the QSPI engine.
package qspi_pkg;

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, DONE, OPEN, GAP} state_e;

    localparam logic [3:0] BITS_SINGLE = 4'd8;
    localparam logic [3:0] BITS_QUAD   = 4'd2;

    localparam logic [3:0] OE_SINGLE  = 4'b0001;
    localparam logic [3:0] OE_QUAD_WR = 4'b1111;
    localparam logic [3:0] OE_IN      = 4'b0000;

    // Single mode always drives sio[0], even on reads, so the command byte can ride along.
    function automatic logic [3:0] oe_for(input logic quad, input logic rd);
        return quad ? (rd ? OE_IN : OE_QUAD_WR) : OE_SINGLE;
    endfunction

endpackage

// File: rtl/qspi_sclk_phase.sv
// qspi_sclk_phase: counts CLK_DIV cycles per SCLK half-period and flags the last cycle of each half.
module qspi_sclk_phase #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic en_i,
    input  logic hi_i,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          phase_end;

    assign phase_end = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_o    = phase_end && !hi_i;
    assign fall_o    = phase_end && hi_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= (phase_end || !en_i) ? '0 : cnt_q + 1'b1;
    end

endmodule

// File: rtl/qspi_multi_cs_engine.sv
// qspi_multi_cs_engine: byte-per-request QSPI master sharing one sio bus across NUM_CS devices,
// each with its own CE and gated SCLK (mode 0).
module qspi_multi_cs_engine
    import qspi_pkg::*;
#(
    parameter int NUM_CS  = 2,
    parameter int CS_W    = NUM_CS > 1 ? $clog2(NUM_CS) : 1,
    parameter int CLK_DIV = 1,
    parameter int CE_GAP  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CS_W-1:0]   req_cs,
    input  logic              req_quad,
    input  logic              req_rd,
    input  logic              req_last,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              busy,
    output logic [NUM_CS-1:0] ce_n,
    output logic [NUM_CS-1:0] sclk,
    input  logic [3:0]        sio_i,
    output logic [3:0]        sio_o,
    output logic [3:0]        sio_oe
);

    localparam int GW = $clog2(CE_GAP + 1);

    state_e            state_q;
    logic [CS_W-1:0]   cs_q;
    logic              quad_q, rd_q, last_q;
    logic [7:0]        sh_q;
    logic [3:0]        bits_q;
    logic [GW-1:0]     gap_q;
    logic [NUM_CS-1:0] ce_n_q, sclk_q;
    logic [3:0]        sio_o_q, sio_oe_q;
    logic              rsp_valid_q;
    logic [7:0]        rsp_rdata_q;

    logic [NUM_CS-1:0] req_sel, cs_sel;
    logic [7:0]        sh_in;
    logic              rise, fall, accept;

    // An out-of-range cs decodes to no select line, so such a byte shifts with every CE and SCLK idle.
    always_comb begin
        req_sel = '0;
        cs_sel  = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            req_sel[i] = req_cs == CS_W'(i);
            cs_sel[i]  = cs_q == CS_W'(i);
        end
    end

    assign sh_in     = quad_q ? {sh_q[3:0], sio_i} : {sh_q[6:0], sio_i[1]};
    assign req_ready = state_q == IDLE || state_q == OPEN;
    assign accept    = req_valid && req_ready;
    assign busy      = state_q != IDLE;

    assign ce_n      = ce_n_q;
    assign sclk      = sclk_q;
    assign sio_o     = sio_o_q;
    assign sio_oe    = sio_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    qspi_sclk_phase #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk    (clk),
        .resetn (resetn),
        .en_i   (state_q == SHIFT_LO || state_q == SHIFT_HI),
        .hi_i   (state_q == SHIFT_HI),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cs_q        <= '0;
            quad_q      <= 1'b0;
            rd_q        <= 1'b0;
            last_q      <= 1'b0;
            sh_q        <= '0;
            bits_q      <= '0;
            gap_q       <= '0;
            ce_n_q      <= '1;
            sclk_q      <= '0;
            sio_o_q     <= '0;
            sio_oe_q    <= OE_IN;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE, OPEN: if (accept) begin
                    if (state_q == IDLE) begin
                        cs_q   <= req_cs;
                        ce_n_q <= ~req_sel;
                    end
                    quad_q   <= req_quad;
                    rd_q     <= req_rd;
                    last_q   <= req_last;
                    sh_q     <= req_wdata;
                    bits_q   <= req_quad ? BITS_QUAD : BITS_SINGLE;
                    sio_o_q  <= req_quad ? req_wdata[7:4] : {3'b000, req_wdata[7]};
                    sio_oe_q <= oe_for(req_quad, req_rd);
                    state_q  <= SHIFT_LO;
                end
                SHIFT_LO: if (rise) begin
                    sclk_q  <= cs_sel;
                    state_q <= SHIFT_HI;
                end
                SHIFT_HI: if (fall) begin
                    sclk_q <= '0;
                    sh_q   <= sh_in;
                    bits_q <= bits_q - 1'b1;
                    if (bits_q == 4'd1) begin
                        sio_o_q     <= '0;
                        sio_oe_q    <= OE_IN;
                        rsp_valid_q <= rd_q;
                        if (rd_q) rsp_rdata_q <= sh_in;
                        state_q     <= DONE;
                    end else begin
                        sio_o_q <= quad_q ? sh_in[7:4] : {3'b000, sh_in[7]};
                        state_q <= SHIFT_LO;
                    end
                end
                DONE: begin
                    gap_q   <= '0;
                    if (last_q) ce_n_q <= '1;
                    state_q <= last_q ? GAP : OPEN;
                end
                GAP: begin
                    gap_q <= gap_q + 1'b1;
                    if (gap_q == GW'(CE_GAP - 1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
